ram_sdp: RTL and testbench

Parametrised simple-dual-port synchronous RAM: one write port with byte strobes and one read port with one-cycle registered latency. A built-in clear engine zeroes the whole array after reset or on request, one word per cycle. It replaces the single-port, single-width memory wherever a datapath needs concurrent read/write, partial-word writes and a known initial state.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_sdp_clr_ctrl.sv | 42 ++++
 rtl/ram_sdp.sv | 67 ++++++
 tb/tb_ram_sdp.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and byte-strobe merge helper for ram_sdp.
package ram_pkg;
  typedef enum logic {RAM_CLEAR, RAM_IDLE} ram_state_e;
  localparam int RAM_MAX_DW = 1024;
  localparam int RAM_MAX_SW = RAM_MAX_DW / 8;
  // Callers zero-extend narrower words; unused upper lanes are ignored.
  function automatic logic [RAM_MAX_DW-1:0] strb_merge(
    input logic [RAM_MAX_DW-1:0] old_word,
    input logic [RAM_MAX_DW-1:0] new_word,
    input logic [RAM_MAX_SW-1:0] strb
  );
    logic [RAM_MAX_DW-1:0] mask;
    for (int i = 0; i < RAM_MAX_SW; i++) mask[8*i +: 8] = {8{strb[i]}};
    return (new_word & mask) | (old_word & ~mask);
  endfunction
endpackage

// File: rtl/ram_sdp_clr_ctrl.sv
// ram_sdp_clr_ctrl: clear FSM and sweep counter that zero the array one word per cycle.
module ram_sdp_clr_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  ram_state_e state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RAM_CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // A clear request while already sweeping is ignored; the sweep never restarts.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == RAM_CLEAR) begin
      state_nx = (cnt == LAST) ? RAM_IDLE : RAM_CLEAR;
      cnt_nx = (cnt == LAST) ? '0 : cnt + AW'(1);
    end else if (clr) begin
      state_nx = RAM_CLEAR;
      cnt_nx = '0;
    end
  end
  assign busy = (state == RAM_CLEAR);
  assign clr_we = busy;
  assign clr_addr = cnt;
endmodule

// File: rtl/ram_sdp.sv
// ram_sdp: simple-dual-port RAM with byte strobes, 1-cycle read and clear engine.
// Define RAM_SDP_WR_FIRST_EN for write-first collisions; default is read-first.
module ram_sdp
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    drop
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > RAM_MAX_DW || DEPTH < 2)
    $error("ram_sdp: DATA_WIDTH must be a multiple of 8 (8..%0d) and DEPTH >= 2", RAM_MAX_DW);
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [SW-1:0]         strb
  );
    return DATA_WIDTH'(strb_merge(RAM_MAX_DW'(old_word), RAM_MAX_DW'(new_word), RAM_MAX_SW'(strb)));
  endfunction
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic clr_we, wr_ok, rd_ok, we;
  logic [ADDR_WIDTH-1:0] clr_addr, waddr;
  logic [DATA_WIDTH-1:0] wr_merged, wword, rword;
  ram_sdp_clr_ctrl #(.DEPTH(DEPTH)) u_clr (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  assign wr_ok = wr_en && !busy && !clr && ({1'b0, wr_addr} < LIM);
  assign rd_ok = rd_en && !busy && !clr && ({1'b0, rd_addr} < LIM);
  assign wr_merged = merge(mem[wr_addr], wr_data, wr_strb);
  assign we = clr_we || wr_ok;
  assign waddr = clr_we ? clr_addr : wr_addr;
  assign wword = clr_we ? '0 : wr_merged;
`ifdef RAM_SDP_WR_FIRST_EN
  assign rword = (wr_ok && wr_addr == rd_addr) ? wr_merged : mem[rd_addr];
`else
  assign rword = mem[rd_addr];
`endif
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wword;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
      drop <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      drop <= (wr_en && !wr_ok) || (rd_en && !rd_ok);
      if (rd_ok) rd_data <= rword;
    end
  end
endmodule

// File: tb/tb_ram_sdp.sv
// tb_ram_sdp: directed checks of ram_sdp at DEPTH=16 (dut a) and DEPTH=12 (dut b).
module tb_ram_sdp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic a_rst, a_clr, a_busy, a_wr_en, a_rd_en, a_rd_valid, a_drop;
  logic [3:0] a_wr_addr, a_rd_addr, a_wr_strb;
  logic [31:0] a_wr_data, a_rd_data;
  logic b_rst, b_clr, b_busy, b_wr_en, b_rd_en, b_rd_valid, b_drop;
  logic [3:0] b_wr_addr, b_rd_addr, b_wr_strb;
  logic [31:0] b_wr_data, b_rd_data;
  ram_sdp #(.DATA_WIDTH(32), .DEPTH(16)) u_a (
    .clk(clk), .rst(a_rst), .clr(a_clr), .busy(a_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_strb(a_wr_strb), .wr_data(a_wr_data), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .drop(a_drop)
  );
  ram_sdp #(.DATA_WIDTH(32), .DEPTH(12)) u_b (
    .clk(clk), .rst(b_rst), .clr(b_clr), .busy(b_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_strb(b_wr_strb), .wr_data(b_wr_data), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .drop(b_drop)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic a_wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_strb = strb;
  endtask
  task automatic a_rd(input logic [3:0] addr);
    a_rd_en = 1'b1; a_rd_addr = addr;
  endtask
  task automatic a_idle();
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr = 1'b0;
  endtask
  initial begin
    int na, nb;
    logic [31:0] exp_col;
    a_rst = 1'b0; b_rst = 1'b0;
    a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_addr = '0; a_rd_addr = '0; a_wr_strb = '0; a_wr_data = '0;
    b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_addr = '0; b_rd_addr = '0; b_wr_strb = '0; b_wr_data = '0;
    tick(); tick();
    chk("a_reset_busy", 32'(a_busy), 32'd1);
    chk("a_reset_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("a_reset_rd_data", a_rd_data, 32'd0);
    chk("a_reset_drop", 32'(a_drop), 32'd0);
    chk("b_reset_busy", 32'(b_busy), 32'd1);
    // Release both resets between edges and count busy-high samples.
    a_rst = 1'b1; b_rst = 1'b1;
    na = 0; nb = 0;
    repeat (24) begin
      if (a_busy) na++;
      if (b_busy) nb++;
      tick();
    end
    chk("a_clear_cycles", 32'(na), 32'd16);
    chk("b_clear_cycles", 32'(nb), 32'd12);
    for (int i = 0; i < 16; i++) begin
      a_rd(4'(i));
      tick();
      chk($sformatf("a_init_valid%0d", i), 32'(a_rd_valid), 32'd1);
      chk($sformatf("a_init_data%0d", i), a_rd_data, 32'd0);
    end
    a_idle();
    tick();
    chk("a_valid_low", 32'(a_rd_valid), 32'd0);
    a_wr(4'd3, 32'hDEADBEEF, 4'b1111); tick();
    a_wr(4'd3, 32'h00001200, 4'b0010); tick();
    a_wr(4'd3, 32'hFFFFFFFF, 4'b0000); tick();
    chk("a_strb0_no_drop", 32'(a_drop), 32'd0);
    a_idle(); a_rd(4'd3); tick();
    chk("a_strb_merge", a_rd_data, 32'hDEAD12EF);
    a_idle(); a_wr(4'd7, 32'h11111111, 4'b1111); tick();
`ifdef RAM_SDP_WR_FIRST_EN
    exp_col = 32'hA5A5A5A5;
`else
    exp_col = 32'h11111111;
`endif
    a_wr(4'd7, 32'hA5A5A5A5, 4'b1111); a_rd(4'd7); tick();
    chk("a_collision", a_rd_data, exp_col);
    a_idle(); a_rd(4'd7); tick();
    chk("a_after_collision", a_rd_data, 32'hA5A5A5A5);
    a_idle(); a_clr = 1'b1; a_wr(4'd2, 32'h55555555, 4'b1111); tick();
    a_idle();
    chk("a_clr_drop", 32'(a_drop), 32'd1);
    na = a_busy ? 1 : 0;
    tick();
    chk("a_clr_drop_pulse", 32'(a_drop), 32'd0);
    repeat (20) begin
      if (a_busy) na++;
      tick();
    end
    chk("a_clr_cycles", 32'(na), 32'd16);
    a_rd(4'd2); tick();
    chk("a_cleared2", a_rd_data, 32'd0);
    a_rd(4'd3); tick();
    chk("a_cleared3", a_rd_data, 32'd0);
    a_idle(); tick();
    // dut b: out-of-range read and a write while clearing
    b_wr_en = 1'b1; b_wr_addr = 4'd4; b_wr_data = 32'hCAFE0001; b_wr_strb = 4'b1111; tick();
    b_wr_en = 1'b0; b_rd_en = 1'b1; b_rd_addr = 4'd4; tick();
    chk("b_rd4", b_rd_data, 32'hCAFE0001);
    b_rd_addr = 4'd13; tick();
    b_rd_en = 1'b0;
    chk("b_oob_drop", 32'(b_drop), 32'd1);
    chk("b_oob_valid", 32'(b_rd_valid), 32'd0);
    chk("b_oob_hold", b_rd_data, 32'hCAFE0001);
    b_clr = 1'b1; tick();
    b_clr = 1'b0; b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 32'hFFFFFFFF; tick();
    b_wr_en = 1'b0;
    chk("b_busy_wr_drop", 32'(b_drop), 32'd1);
    repeat (20) tick();
    chk("b_idle", 32'(b_busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      b_rd_en = 1'b1; b_rd_addr = 4'(i); tick();
      chk($sformatf("b_zero%0d", i), b_rd_data, 32'd0);
    end
    b_rd_en = 1'b0;
    // dut a: reset in the middle of a clear restarts the full sweep
    a_clr = 1'b1; tick();
    a_clr = 1'b0;
    repeat (4) tick();
    chk("a_midclr_busy", 32'(a_busy), 32'd1);
    a_rst = 1'b0; #1;
    chk("a_rst_busy", 32'(a_busy), 32'd1);
    chk("a_rst_valid", 32'(a_rd_valid), 32'd0);
    tick(); tick();
    a_rst = 1'b1;
    na = 0;
    repeat (24) begin
      if (a_busy) na++;
      tick();
    end
    chk("a_restart_cycles", 32'(na), 32'd16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
